// File: rtl/conv_read_seq.sv
// rtl/conv_read_seq.sv - raster-order read address sequencer for the Conv2d feature-map buffer
// Optional stride-2 window decimation is enabled by defining READ_STRIDE2_EN.
module conv_read_seq #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 5,
  parameter int ADDR_BITS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [ROW_BITS-1:0]          cfg_rows,
  input  logic [COL_BITS-1:0]          cfg_cols,
  input  logic [ADDR_BITS-1:0]         cfg_base,
`ifdef READ_STRIDE2_EN
  input  logic                         cfg_stride2,
`endif
  input  logic                         abort,
  output logic                         addr_valid,
  input  logic                         addr_ready,
  output logic [ADDR_BITS-1:0]         rd_addr,
  output logic [ROW_BITS-1:0]          row_idx,
  output logic [COL_BITS-1:0]          col_idx,
  output logic                         row_last,
  output logic                         frame_last,
  output logic [ROW_BITS+COL_BITS-1:0] beats_left,
  output logic                         busy,
  output logic                         done
);

  localparam int BL_BITS = ROW_BITS + COL_BITS;
  localparam logic [COL_BITS-1:0] C_ONE  = COL_BITS'(1);
  localparam logic [BL_BITS-1:0]  BL_ONE = BL_BITS'(1);
  localparam logic [BL_BITS-1:0]  BL_TWO = BL_BITS'(2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic [ADDR_BITS-1:0] rd_addr_n, row_base, row_base_n;
  logic [ROW_BITS-1:0]  row_idx_n;
  logic [COL_BITS-1:0]  col_idx_n;
  logic                 row_last_n, frame_last_n;
  logic [BL_BITS-1:0]   beats_left_n;
  // cols_q drives the row address step; ncols_q/col_cnt count visited columns.
  logic [COL_BITS-1:0]  cols_q, cols_n, ncols_q, ncols_n, col_cnt, col_cnt_n;
  logic                 stride_q, stride_n;
  logic                 clr;

  logic                 stride_in;
  logic [ROW_BITS-1:0]  nrows_vis;
  logic [COL_BITS-1:0]  ncols_vis;
  logic [BL_BITS-1:0]   total;
  logic [ADDR_BITS-1:0] addr_step, row_step;
  logic [COL_BITS-1:0]  col_step;
  logic [ROW_BITS-1:0]  ridx_step;

`ifdef READ_STRIDE2_EN
  assign stride_in = cfg_stride2;
`else
  assign stride_in = 1'b0;
`endif

  // Visited counts: ceil(n/2) when decimating, n otherwise.
  assign nrows_vis = stride_in ? ((cfg_rows >> 1) + ROW_BITS'(cfg_rows[0])) : cfg_rows;
  assign ncols_vis = stride_in ? ((cfg_cols >> 1) + COL_BITS'(cfg_cols[0])) : cfg_cols;
  assign total     = BL_BITS'(nrows_vis) * BL_BITS'(ncols_vis);

  assign addr_step = stride_q ? ADDR_BITS'(2) : ADDR_BITS'(1);
  assign col_step  = stride_q ? COL_BITS'(2) : COL_BITS'(1);
  assign ridx_step = stride_q ? ROW_BITS'(2) : ROW_BITS'(1);
  assign row_step  = stride_q ? ADDR_BITS'({cols_q, 1'b0}) : ADDR_BITS'(cols_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      row_base   <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      row_last   <= 1'b0;
      frame_last <= 1'b0;
      beats_left <= '0;
      cols_q     <= '0;
      ncols_q    <= '0;
      col_cnt    <= '0;
      stride_q   <= 1'b0;
    end else begin
      state      <= state_n;
      rd_addr    <= rd_addr_n;
      row_base   <= row_base_n;
      row_idx    <= row_idx_n;
      col_idx    <= col_idx_n;
      row_last   <= row_last_n;
      frame_last <= frame_last_n;
      beats_left <= beats_left_n;
      cols_q     <= cols_n;
      ncols_q    <= ncols_n;
      col_cnt    <= col_cnt_n;
      stride_q   <= stride_n;
    end
  end

  always_comb begin
    state_n      = state;
    rd_addr_n    = rd_addr;
    row_base_n   = row_base;
    row_idx_n    = row_idx;
    col_idx_n    = col_idx;
    row_last_n   = row_last;
    frame_last_n = frame_last;
    beats_left_n = beats_left;
    cols_n       = cols_q;
    ncols_n      = ncols_q;
    col_cnt_n    = col_cnt;
    stride_n     = stride_q;
    clr          = 1'b0;

    case (state)
      IDLE: begin
        if (start_valid) begin
          if (cfg_rows != '0 && cfg_cols != '0) begin
            state_n      = RUN;
            rd_addr_n    = cfg_base;
            row_base_n   = cfg_base;
            row_idx_n    = '0;
            col_idx_n    = '0;
            cols_n       = cfg_cols;
            ncols_n      = ncols_vis;
            col_cnt_n    = '0;
            stride_n     = stride_in;
            beats_left_n = total;
            row_last_n   = (ncols_vis == C_ONE);
            frame_last_n = (total == BL_ONE);
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          clr     = 1'b1;
        end else if (addr_ready) begin
          beats_left_n = beats_left - BL_ONE;
          frame_last_n = (beats_left == BL_TWO);
          if (frame_last) begin
            state_n = DONE;
            clr     = 1'b1;
          end else if (row_last) begin
            col_idx_n  = '0;
            col_cnt_n  = '0;
            row_idx_n  = row_idx + ridx_step;
            rd_addr_n  = row_base + row_step;
            row_base_n = row_base + row_step;
            row_last_n = (ncols_q == C_ONE);
          end else begin
            col_idx_n  = col_idx + col_step;
            col_cnt_n  = col_cnt + C_ONE;
            rd_addr_n  = rd_addr + addr_step;
            row_last_n = ((col_cnt + C_ONE) == (ncols_q - C_ONE));
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        clr     = 1'b1;
      end
    endcase

    if (clr) begin
      rd_addr_n    = '0;
      row_base_n   = '0;
      row_idx_n    = '0;
      col_idx_n    = '0;
      row_last_n   = 1'b0;
      frame_last_n = 1'b0;
      beats_left_n = '0;
      col_cnt_n    = '0;
    end
  end

  assign start_ready = (state == IDLE);
  assign addr_valid  = (state == RUN);
  assign busy        = (state != IDLE);
  // An abort landing on the DONE cycle suppresses the pulse.
  assign done        = (state == DONE) && !abort;

endmodule

// File: tb/tb_conv_read_seq.sv
// tb/tb_conv_read_seq.sv - self-checking bench for conv_read_seq
module tb_conv_read_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [4:0] cfg_rows = '0;
  logic [4:0] cfg_cols = '0;
  logic [9:0] cfg_base = '0;
  logic       cfg_stride2 = 1'b0;
  logic       abort = 1'b0;
  logic       addr_valid;
  logic       addr_ready = 1'b0;
  logic [9:0] rd_addr;
  logic [4:0] row_idx;
  logic [4:0] col_idx;
  logic       row_last;
  logic       frame_last;
  logic [9:0] beats_left;
  logic       busy;
  logic       done;

  conv_read_seq dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_base(cfg_base),
`ifdef READ_STRIDE2_EN
    .cfg_stride2(cfg_stride2),
`endif
    .abort(abort),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .rd_addr(rd_addr), .row_idx(row_idx), .col_idx(col_idx),
    .row_last(row_last), .frame_last(frame_last), .beats_left(beats_left),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] addr;
    logic [4:0] row;
    logic [4:0] col;
    logic       rl;
    logic       fl;
    logic [9:0] bl;
  } beat_t;

  // Model: 0 idle, 1 emitting beats, 2 done pulse
  beat_t q[$];
  int    mode = 0;
  bit    cleared = 1'b1;
  bit    chk_en = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [9:0] a_log[$];
  bit         rl_log[$];
  int         bl_log[$];
  int acc_cyc, first_valid_cyc, last_xfer_cyc, done_cyc, done_cnt, valid_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Every visited element in raster order, address taken straight from base + r*cols + c.
  task automatic build(input int rows, input int cols, input int base, input int st);
    int    step, n;
    beat_t b;
    step = st ? 2 : 1;
    n = ((rows + step - 1) / step) * ((cols + step - 1) / step);
    q.delete();
    for (int r = 0; r < rows; r += step)
      for (int c = 0; c < cols; c += step) begin
        b.addr = 10'(base + r * cols + c);
        b.row  = 5'(r);
        b.col  = 5'(c);
        b.rl   = (c + step >= cols);
        b.bl   = 10'(n - q.size());
        b.fl   = (b.bl == 10'd1);
        q.push_back(b);
      end
  endtask

  always @(posedge clk) begin
    int st;
`ifdef READ_STRIDE2_EN
    st = int'(cfg_stride2);
`else
    st = 0;
`endif
    if (reset) begin
      mode = 0; q.delete(); cleared = 1'b1; chk_en = 1'b1;
    end else begin
      case (mode)
        0: if (start_valid) begin
             build(int'(cfg_rows), int'(cfg_cols), int'(cfg_base), st);
             cleared = 1'b0;
             mode = (q.size() != 0) ? 1 : 2;
           end
        1: if (abort) begin
             mode = 0; q.delete(); cleared = 1'b1;
           end else if (addr_ready) begin
             void'(q.pop_front());
             if (q.size() == 0) mode = 2;
           end
        default: begin
          if (abort) cleared = 1'b1;
          mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("start_ready", 32'(start_ready), 32'(mode == 0));
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("addr_valid", 32'(addr_valid), 32'(mode == 1));
      chk("done", 32'(done), 32'(mode == 2 && !abort));
      if (mode == 1 && q.size() != 0) begin
        chk("rd_addr", 32'(rd_addr), 32'(q[0].addr));
        chk("row_idx", 32'(row_idx), 32'(q[0].row));
        chk("col_idx", 32'(col_idx), 32'(q[0].col));
        chk("row_last", 32'(row_last), 32'(q[0].rl));
        chk("frame_last", 32'(frame_last), 32'(q[0].fl));
        chk("beats_left", 32'(beats_left), 32'(q[0].bl));
      end else if (mode != 1 && cleared) begin
        chk("clr_rd_addr", 32'(rd_addr), 32'd0);
        chk("clr_row_idx", 32'(row_idx), 32'd0);
        chk("clr_col_idx", 32'(col_idx), 32'd0);
        chk("clr_row_last", 32'(row_last), 32'd0);
        chk("clr_frame_last", 32'(frame_last), 32'd0);
        chk("clr_beats_left", 32'(beats_left), 32'd0);
      end
      if (start_valid && start_ready && !reset) acc_cyc = cyc;
      if (addr_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (addr_ready && !abort && !reset) begin
          a_log.push_back(rd_addr);
          rl_log.push_back(row_last);
          bl_log.push_back(int'(beats_left));
          if (frame_last) last_xfer_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_logs();
    a_log.delete(); rl_log.delete(); bl_log.delete();
    acc_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1;
    done_cyc = -1; done_cnt = 0; valid_cnt = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (mode == 0) return;
      @(posedge clk); #1;
    end
    chk("wait_idle_timeout", 32'(mode), 32'd0);
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating. kill 1: abort, 2: reset at the 3rd handshake.
  task automatic do_job(input int rows, input int cols, input int base, input int st,
                        input int pat, input int kill);
    bit killed, fin;
    wait_idle();
    clear_logs();
    @(posedge clk); #1;
    start_valid = 1'b1;
    cfg_rows = 5'(rows); cfg_cols = 5'(cols); cfg_base = 10'(base); cfg_stride2 = st[0];
    addr_ready = 1'b1;
    killed = 1'b0; fin = 1'b0;
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
      start_valid = 1'b0; abort = 1'b0; reset = 1'b0;
      cfg_rows = 5'($urandom); cfg_cols = 5'($urandom); cfg_base = 10'($urandom);
      cfg_stride2 = 1'($urandom);
      if (mode == 0) begin
        fin = 1'b1;
        break;
      end
      addr_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
      if (kill != 0 && !killed && a_log.size() == 2) begin
        killed = 1'b1;
        addr_ready = 1'b1;
        if (kill == 1) abort = 1'b1;
        else reset = 1'b1;
      end
    end
    if (!fin) chk("job_timeout", 32'(mode), 32'd0);
  endtask

  task automatic chk_seq(input string nm, input logic [9:0] exp_a[], input bit exp_rl[]);
    chk({nm, "_len"}, 32'(a_log.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < a_log.size(); i++) begin
      chk({nm, "_addr"}, 32'(a_log[i]), 32'(exp_a[i]));
      chk({nm, "_rl"}, 32'(rl_log[i]), 32'(exp_rl[i]));
      chk({nm, "_bl"}, 32'(bl_log[i]), 32'(exp_a.size() - i));
    end
    chk({nm, "_first_valid"}, 32'(first_valid_cyc), 32'(acc_cyc + 1));
    chk({nm, "_done_time"}, 32'(done_cyc), 32'(last_xfer_cyc + 1));
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [9:0] a6[] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015};
    bit         r6[] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0] aw[] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    bit         rw[] = '{1'b0, 1'b0, 1'b0, 1'b1};
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    do_job(2, 3, 'h010, 0, 0, 0);
    chk_seq("j2x3", a6, r6);
    do_job(2, 3, 'h010, 0, 1, 0);
    chk_seq("j2x3_stall", a6, r6);
    do_job(1, 4, 'h3FE, 0, 0, 0);
    chk_seq("jwrap", aw, rw);

    do_job(0, 5, 'h123, 0, 0, 0);
    chk("empty_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("empty_done_time", 32'(done_cyc), 32'(acc_cyc + 1));
    chk("empty_done_cnt", 32'(done_cnt), 32'd1);

    do_job(2, 3, 'h010, 0, 0, 1);
    chk("abort_xfers", 32'(a_log.size()), 32'd2);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    do_job(2, 3, 'h010, 0, 0, 0);
    chk_seq("after_abort", a6, r6);

    do_job(2, 3, 'h010, 0, 0, 2);
    chk("reset_xfers", 32'(a_log.size()), 32'd2);
    chk("reset_no_done", 32'(done_cnt), 32'd0);
    do_job(2, 3, 'h010, 0, 1, 0);
    chk_seq("after_reset", a6, r6);

`ifdef READ_STRIDE2_EN
    begin
      logic [9:0] as[] = '{10'd0, 10'd2, 10'd6, 10'd8};
      bit         rs[] = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_job(3, 3, 0, 1, 0, 0);
      chk_seq("stride2", as, rs);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start_valid = ($urandom % 4 == 0);
      cfg_rows    = 5'($urandom_range(0, 5));
      cfg_cols    = 5'($urandom_range(0, 6));
      cfg_base    = 10'($urandom);
      cfg_stride2 = 1'($urandom);
      addr_ready  = ($urandom % 4 != 0);
      abort       = ($urandom % 64 == 0);
      reset       = ($urandom % 500 == 0);
    end
    @(posedge clk); #1;
    start_valid = 1'b0; abort = 1'b0; reset = 1'b0; addr_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_read_seq.md
# conv_read_seq

Read-side address sequencer for the Conv2d feature-map buffer. The write side fills the buffer with a free-running up-counter; this block reads a configured rows×cols window back out in raster order. It emits one read address per valid/ready beat together with row/column indices, a row-last flag, a frame-last flag and a down-counting remaining-beats value. It accepts a job through a start handshake and signals completion with a one-cycle done pulse.

## Interface
- ROW_BITS, 5, width of row count/index
- COL_BITS, 5, width of column count/index
- ADDR_BITS, 10, width of buffer read address
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  job request; cfg_* sampled when start_valid && start_ready
- start_ready  out  1  high only in IDLE
- cfg_rows  in  ROW_BITS  rows in window (0 = empty job)
- cfg_cols  in  COL_BITS  columns in window (0 = empty job)
- cfg_base  in  ADDR_BITS  address of element (0,0)
- abort  in  1  cancel current job
- addr_valid  out  1  rd_addr and side-band outputs valid
- addr_ready  in  1  consumer accepts beat
- rd_addr  out  ADDR_BITS  read address
- row_idx  out  ROW_BITS  current row
- col_idx  out  COL_BITS  current column
- row_last  out  1  col_idx is the last column of the row
- frame_last  out  1  final beat of the job
- beats_left  out  ROW_BITS+COL_BITS  beats not yet accepted, including the current one
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on accept when cfg_rows != 0 && cfg_cols != 0. At accept, latch the config, clear row_idx and col_idx, set rd_addr = cfg_base, beats_left = cfg_rows*cfg_cols.
- IDLE → DONE on accept when either count is 0. No beats are emitted.
- RUN: addr_valid = 1. A beat transfers when addr_valid && addr_ready.
  - On each transfer: beats_left decrements.
  - Not row_last: col_idx+1, rd_addr+1.
  - row_last and not frame_last: col_idx = 0, row_idx+1, rd_addr = row_base + cols, where row_base is a register holding the row-start address. Without the stride feature this equals rd_addr+1.
  - Transfer of the frame_last beat: go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Outputs hold stable while addr_valid && !addr_ready.
- Address arithmetic is modulo 2^ADDR_BITS; wrap past the top is legal and silent.
- abort in RUN or DONE: go to IDLE next cycle and clear all outputs; no done pulse. abort has priority over a same-cycle transfer. abort in IDLE has no effect.
- reset mid-job behaves like abort and additionally clears all registers.
- start_valid outside IDLE is ignored; config inputs are not re-sampled mid-job.

## Timing
- Reset values: start_ready=1, addr_valid=0, rd_addr=0, row_idx=0, col_idx=0, row_last=0, frame_last=0, beats_left=0, busy=0, done=0.
- Accept at cycle T: addr_valid=1 and first beat presented at T+1.
- Throughput: one beat per cycle while addr_ready=1. Zero bubbles at row boundaries.
- Last beat transferred at cycle U: done=1 and addr_valid=0 at U+1; start_ready=1 at U+2.
- Empty job accepted at T: done=1 at T+1, start_ready=1 at T+2.
- row_last and frame_last are registered, and are valid in the same cycle as their beat.

## Configuration
- READ_STRIDE2_EN defined: adds input cfg_stride2 (1 bit), sampled at accept.
  - When 1, only even rows and even columns are visited, giving ceil(rows/2)*ceil(cols/2) beats.
  - Column step is rd_addr+2; row step is row_base + 2*cols.
  - beats_left loads the reduced count; row_last and frame_last refer to the last visited element.
  - When cfg_stride2=0, behaviour is identical to the undefined build.
- Undefined: no cfg_stride2 port; unit stride only.

## Test plan
- rows=2, cols=3, base=0x010, addr_ready=1 → rd_addr 0x010..0x015 on consecutive cycles; row_last on beats 3 and 6; frame_last on beat 6; beats_left 6→1; done one cycle after beat 6.
- Same job with addr_ready toggled 1,0,0,1,… → outputs held while ready=0; same 6-address sequence; done only after the 6th transfer.
- base=0x3FE, rows=1, cols=4 → rd_addr 0x3FE, 0x3FF, 0x000, 0x001.
- rows=0, cols=5 → no addr_valid; done at T+1; start_ready again at T+2.
- abort asserted together with the 3rd handshake of a 2×3 job → addr_valid=0 next cycle, IDLE, done never pulses; a new job is accepted two cycles later. Repeat the same case with reset instead of abort and check that reset values are restored.
- READ_STRIDE2_EN, stride2=1, rows=3, cols=3, base=0 → addresses 0, 2, 6, 8; row_last on 2 and 8; beats_left 4→1.
